// File: rtl/canvas_streamer.sv
// Streams the ROWS x COLS canvas in raster order over valid/ready, reading a synchronous
// 1-cycle-latency read port and absorbing backpressure in a 2-entry skid buffer.
module canvas_streamer #(
    parameter int ROWS   = 28,
    parameter int COLS   = 28,
    parameter int DATA_W = 16,
    parameter int PIX_W  = 8,
    parameter int IDX_W  = 10
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Start,
    input  logic              Abort,
    output logic              Busy,
    output logic              Done,
    output logic [4:0]        Rd_Row,
    output logic [4:0]        Rd_Col,
    input  logic [DATA_W-1:0] Rd_Data,
    output logic [PIX_W-1:0]  Pix_Data,
    output logic [IDX_W-1:0]  Pix_Index,
    output logic              Pix_Valid,
    input  logic              Pix_Ready,
    output logic              Pix_Last
);
    localparam int TOTAL = ROWS * COLS;

    typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DONE} state_t;

    state_t           r_state, w_next;
    logic [4:0]       r_row, r_col;
    logic             r_all_issued, r_inflight;
    logic [PIX_W-1:0] r_buf [2];
    logic             r_wr_ptr, r_rd_ptr;
    logic [1:0]       r_count;
    logic [IDX_W-1:0] r_out_idx;

    logic             w_issue, w_pop, w_push, w_buf_pop, w_valid, w_last_hs, w_clr, w_addr_end;
    logic [PIX_W-1:0] w_rd_pix;
    logic [1:0]       w_occ;
    logic             w_unused;

    assign w_rd_pix   = Rd_Data[DATA_W-1 -: PIX_W];
    assign w_unused   = &{1'b0, Rd_Data};
    assign w_occ      = r_count + {1'b0, r_inflight};
    assign w_valid    = (r_count != 2'd0) || r_inflight;
    assign w_pop      = w_valid && Pix_Ready;
    assign w_buf_pop  = w_pop && (r_count != 2'd0);
    // Returning read data bypasses the buffer when it is empty and the consumer takes it now.
    assign w_push     = r_inflight && !((r_count == 2'd0) && Pix_Ready);
    assign w_issue    = (r_state == ST_STREAM) && !r_all_issued && (w_occ < 2'd2);
    assign w_last_hs  = w_pop && (r_out_idx == IDX_W'(TOTAL - 1));
    assign w_addr_end = (r_row == 5'(ROWS - 1)) && (r_col == 5'(COLS - 1));
    assign w_clr      = (w_next != ST_STREAM);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= ST_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        Busy   = 1'b0;
        Done   = 1'b0;
        case (r_state)
            ST_IDLE:   if (Start && !Abort) w_next = ST_STREAM;
            ST_STREAM: begin
                Busy = 1'b1;
                if (Abort)          w_next = ST_IDLE;
                else if (w_last_hs) w_next = ST_DONE;
            end
            ST_DONE: begin
                Done   = 1'b1;
                w_next = ST_IDLE;
            end
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_row        <= '0;
            r_col        <= '0;
            r_all_issued <= 1'b0;
            r_inflight   <= 1'b0;
            r_buf[0]     <= '0;
            r_buf[1]     <= '0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= '0;
            r_out_idx    <= '0;
        end else if (w_clr) begin
            r_row        <= '0;
            r_col        <= '0;
            r_all_issued <= 1'b0;
            r_inflight   <= 1'b0;
            r_wr_ptr     <= 1'b0;
            r_rd_ptr     <= 1'b0;
            r_count      <= '0;
            r_out_idx    <= '0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                if (w_addr_end) begin
                    r_all_issued <= 1'b1;
                end else if (r_col == 5'(COLS - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 5'd1;
                end else begin
                    r_col <= r_col + 5'd1;
                end
            end
            if (w_push) begin
                r_buf[r_wr_ptr] <= w_rd_pix;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_buf_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_buf_pop};
            if (w_pop) r_out_idx <= r_out_idx + 1'b1;
        end
    end

    assign Rd_Row    = r_row;
    assign Rd_Col    = r_col;
    assign Pix_Valid = w_valid;
    assign Pix_Index = r_out_idx;
    assign Pix_Last  = w_valid && (r_out_idx == IDX_W'(TOTAL - 1));
    assign Pix_Data  = !w_valid ? '0 : ((r_count != 2'd0) ? r_buf[r_rd_ptr] : w_rd_pix);

endmodule

// File: tb/tb_canvas_streamer.sv
// Directed bench for canvas_streamer: cycle table for start/latency/backpressure/abort,
// then full-frame sequences for throughput, stalls, restart rules, reset and abort.
module tb_canvas_streamer;
    localparam int ROWS  = 28;
    localparam int COLS  = 28;
    localparam int TOTAL = ROWS * COLS;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Start = 1'b0;
    logic        Abort = 1'b0;
    logic        Pix_Ready = 1'b0;
    logic        Busy, Done, Pix_Valid, Pix_Last;
    logic [4:0]  Rd_Row, Rd_Col;
    logic [15:0] Rd_Data = '0;
    logic [7:0]  Pix_Data;
    logic [9:0]  Pix_Index;
    bit          swap = 1'b0;

    int total = 0;
    int bad   = 0;

    canvas_streamer #(.ROWS(ROWS), .COLS(COLS), .DATA_W(16), .PIX_W(8), .IDX_W(10)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Abort(Abort),
        .Busy(Busy), .Done(Done), .Rd_Row(Rd_Row), .Rd_Col(Rd_Col), .Rd_Data(Rd_Data),
        .Pix_Data(Pix_Data), .Pix_Index(Pix_Index), .Pix_Valid(Pix_Valid),
        .Pix_Ready(Pix_Ready), .Pix_Last(Pix_Last)
    );

    always #5 Clk = ~Clk;

    // Canvas model: synchronous read, word = {row, col} or {col, row} when swapped.
    always @(posedge Clk)
        Rd_Data <= swap ? {3'b0, Rd_Col, 3'b0, Rd_Row} : {3'b0, Rd_Row, 3'b0, Rd_Col};

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int exp_pix(input int i);
        return swap ? (i % COLS) : (i / COLS);
    endfunction

    task automatic start_frame();
        @(negedge Clk);
        Start = 1'b1;
        Abort = 1'b0;
        @(negedge Clk);
        Start = 1'b0;
        #1;
        chk("busy_after_start", Busy, 1);
        chk("addr_first", {Rd_Row, Rd_Col}, 0);
    endtask

    // rmode 0: always ready; 1: 1,0,0,1 pattern then random stalls.
    task automatic run_stream(input int rmode, input int stop_at, input bit hold_start, input int repulse_at);
        int expi  = 0;
        int cyc   = 0;
        int dones = 0;
        bit seen  = 1'b0;
        while (expi < TOTAL && expi != stop_at && cyc < 20000) begin
            if (rmode == 0)    Pix_Ready = 1'b1;
            else if (cyc < 40) Pix_Ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            else               Pix_Ready = ($urandom_range(0, 3) != 0);
            Start = hold_start || (expi == repulse_at);
            #1;
            if (Done) dones++;
            if (rmode == 0 && cyc == 0) chk("valid_latency", Pix_Valid, 0);
            if (rmode == 0 && seen)     chk("no_bubble", Pix_Valid, 1);
            if (Pix_Valid) begin
                seen = 1'b1;
                chk("pix_index", Pix_Index, expi);
                chk("pix_data", Pix_Data, exp_pix(expi));
                chk("pix_last", Pix_Last, int'(expi == TOTAL - 1));
                chk("busy_stream", Busy, 1);
                if (Pix_Ready) expi++;
            end
            @(negedge Clk);
            cyc++;
        end
        Start = 1'b0;
        chk("done_during_stream", dones, 0);
        if (cyc >= 20000) begin
            chk("stream_timeout", expi, TOTAL);
        end else if (expi == TOTAL) begin
            if (rmode == 0) chk("frame_cycles", cyc, TOTAL + 1);
            Start = hold_start;
            #1;
            chk("done_pulse", Done, 1);
            chk("done_busy", Busy, 0);
            chk("done_valid", Pix_Valid, 0);
            @(negedge Clk);
            #1;
            chk("done_single", Done, 0);
            chk("idle_busy", Busy, 0);
            @(negedge Clk);
            #1;
            chk("restart_after_idle", Busy, int'(hold_start));
            Start = 1'b0;
            if (hold_start) begin
                Abort = 1'b1;
                @(negedge Clk);
                Abort = 1'b0;
                #1;
                chk("abort2_busy", Busy, 0);
                chk("abort2_valid", Pix_Valid, 0);
            end
        end
    endtask

    typedef struct {
        logic start, abort, ready;
        logic busy, valid;
        int   idx, data, row, col;
        logic done;
    } vec_t;

    initial begin
        vec_t v[11];
        v[0]  = '{1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
        v[1]  = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
        v[2]  = '{1, 0, 0, 1, 0, 0, 0, 0, 0, 0};
        v[3]  = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 0};
        v[4]  = '{0, 0, 0, 1, 1, 0, 0, 0, 2, 0};
        v[5]  = '{0, 0, 0, 1, 1, 0, 0, 0, 2, 0};
        v[6]  = '{0, 0, 1, 1, 1, 1, 1, 0, 2, 0};
        v[7]  = '{0, 0, 1, 1, 1, 2, 2, 0, 3, 0};
        v[8]  = '{0, 0, 1, 1, 1, 3, 3, 0, 4, 0};
        v[9]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
        v[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

        #12;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_valid", Pix_Valid, 0);
        chk("rst_last", Pix_Last, 0);
        chk("rst_addr", {Rd_Row, Rd_Col}, 0);
        chk("rst_pix", {Pix_Data, Pix_Index}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        swap = 1'b1;
        for (int i = 0; i < 11; i++) begin
            Start = v[i].start;
            Abort = v[i].abort;
            Pix_Ready = v[i].ready;
            @(negedge Clk);
            #1;
            chk($sformatf("vec%0d_busy", i), Busy, v[i].busy);
            chk($sformatf("vec%0d_valid", i), Pix_Valid, v[i].valid);
            chk($sformatf("vec%0d_idx", i), Pix_Index, v[i].idx);
            chk($sformatf("vec%0d_data", i), Pix_Data, v[i].data);
            chk($sformatf("vec%0d_row", i), Rd_Row, v[i].row);
            chk($sformatf("vec%0d_col", i), Rd_Col, v[i].col);
            chk($sformatf("vec%0d_done", i), Done, v[i].done);
        end
        Start = 1'b0;
        Abort = 1'b0;

        // T1 full-rate frame; T2 stalled frame
        swap = 1'b0;
        start_frame();
        run_stream(0, -1, 1'b0, -1);
        start_frame();
        run_stream(1, -1, 1'b0, -1);

        // T3 re-pulse mid-frame, then Start held throughout
        start_frame();
        run_stream(0, -1, 1'b0, 100);
        start_frame();
        run_stream(0, -1, 1'b1, -1);

        // T4 asynchronous reset mid-frame
        swap = 1'b1;
        start_frame();
        run_stream(1, 400, 1'b0, -1);
        #1;
        Reset_n = 1'b0;
        #1;
        chk("midrst_valid", Pix_Valid, 0);
        chk("midrst_busy", Busy, 0);
        chk("midrst_pix", {Pix_Data, Pix_Index}, 0);
        chk("midrst_addr", {Rd_Row, Rd_Col}, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            #1;
            chk("midrst_no_done", Done, 0);
        end
        start_frame();
        run_stream(0, -1, 1'b0, -1);

        // T5 abort while stalled
        start_frame();
        run_stream(0, 500, 1'b0, -1);
        Pix_Ready = 1'b0;
        Abort = 1'b1;
        #1;
        chk("abort_valid_before", Pix_Valid, 1);
        @(negedge Clk);
        Abort = 1'b0;
        #1;
        chk("abort_valid", Pix_Valid, 0);
        chk("abort_busy", Busy, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge Clk);
            #1;
            chk("abort_no_done", Done, 0);
        end
        start_frame();
        run_stream(0, -1, 1'b0, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
